pulse_period_meter: RTL and testbench

Measures the interval between rising edges of a periodic pulse stream and reports it in whole milliseconds. This is the receive-side counterpart of the periodic sampling pulse generator. It lets a host or a downstream peripheral check or track a pulse rate, for example the sampling strobe of a quadrature peripheral or an externally supplied rate pulse. It also flags loss of the pulse stream with a timeout.

---
 rtl/pulse_period_meter.sv | 127 ++++++++++++
 tb/tb_pulse_period_meter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_meter.sv
// Measures the interval between rising edges of pulse_in in whole milliseconds, with loss-of-stream timeout.
// Define PULSE_SYNC_EN to pass pulse_in through a 2-flop synchronizer (adds 2 clk of latency).
module pulse_period_meter #(
  parameter int CLK_FREQUENCY = 50_000_000,
  parameter int TIMEOUT_MS    = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pulse_in,
  output logic [7:0] period_ms,
  output logic       valid,
  output logic       new_sample,
  output logic       timeout
);

  localparam int MS_CYCLES = CLK_FREQUENCY / 1000;
  localparam int PW        = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST   = PW'(MS_CYCLES - 1);
  localparam logic [7:0]    TIMEOUT_LAST = 8'(TIMEOUT_MS - 1);

  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_TIMEOUT} state_t;

  state_t        state, next_state;
  logic          pulse_s, sample_ok;
  logic          prev, armed, rise;
  logic [PW-1:0] presc;
  logic [7:0]    ms_count, ms_next;
  logic          tick, expire, take_sample, go_timeout;

`ifdef PULSE_SYNC_EN
  logic sync1, sync2, fill1, fill2;

  // fill1/fill2 mark when sync2 carries a real post-reset sample of pulse_in
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      fill1 <= 1'b0;
      fill2 <= 1'b0;
    end else begin
      sync1 <= pulse_in;
      sync2 <= sync1;
      fill1 <= 1'b1;
      fill2 <= fill1;
    end
  end

  assign pulse_s   = sync2;
  assign sample_ok = fill2;
`else
  assign pulse_s   = pulse_in;
  assign sample_ok = 1'b1;
`endif

  // An edge is only accepted once the input has been seen low after reset,
  // so a level held high through reset release never counts as a boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      prev <= pulse_s;
      if (sample_ok && !pulse_s) armed <= 1'b1;
    end
  end

  assign rise = pulse_s & ~prev & armed;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (rise) next_state = S_MEASURE;
      S_MEASURE: if (!rise && expire) next_state = S_TIMEOUT;
      S_TIMEOUT: if (rise) next_state = S_MEASURE;
      default:   next_state = S_IDLE;
    endcase
  end

  // A tick landing on the same cycle as an edge is folded into the captured value.
  always_comb begin
    tick        = (state == S_MEASURE) && (presc == PRESC_LAST);
    ms_next     = (ms_count == 8'd255) ? 8'd255 : ms_count + {7'b0, tick};
    expire      = tick && (ms_count == TIMEOUT_LAST);
    take_sample = (state == S_MEASURE) && rise;
    go_timeout  = (state == S_MEASURE) && !rise && expire;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc      <= '0;
      ms_count   <= '0;
      period_ms  <= '0;
      valid      <= 1'b0;
      new_sample <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      new_sample <= take_sample;

      if (rise) begin
        presc    <= '0;
        ms_count <= '0;
      end else if (state == S_MEASURE) begin
        presc    <= tick ? '0 : presc + 1'b1;
        ms_count <= ms_next;
      end

      if (take_sample) begin
        period_ms <= ms_next;
        valid     <= 1'b1;
      end

      if (go_timeout) begin
        timeout   <= 1'b1;
        valid     <= 1'b0;
        period_ms <= '0;
      end

      if ((state == S_TIMEOUT) && rise) timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Testbench for pulse_period_meter: scaled clock (10 clk per ms, 20 ms timeout), table-driven
// pulse trains, hand-written corner sequences and random trains, all checked against an edge-time model.
module tb_pulse_period_meter;

  localparam int CLK_FREQUENCY = 10_000;
  localparam int MS            = CLK_FREQUENCY / 1000;
  localparam int TIMEOUT_MS    = 20;
  localparam int TO_CYC        = TIMEOUT_MS * MS;
`ifdef PULSE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       pulse_in;
  logic [7:0] period_ms;
  logic       valid;
  logic       new_sample;
  logic       timeout;

  pulse_period_meter #(
    .CLK_FREQUENCY(CLK_FREQUENCY),
    .TIMEOUT_MS   (TIMEOUT_MS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pulse_in  (pulse_in),
    .period_ms (period_ms),
    .valid     (valid),
    .new_sample(new_sample),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;
  int cycle        = 0;
  int strobes      = 0;

  // Reference model: raw input history since reset plus the time of the last accepted edge.
  logic       hist[$];
  int         mode;
  int         last_t;
  logic [7:0] exp_period;
  logic       exp_valid, exp_new, exp_timeout;

  typedef struct {
    int         gap;
    int         high;
    int         reps;
    int         exp_samples;
    logic [7:0] exp_period;
  } seg_t;

  seg_t segs[9];

  task automatic model_step(input logic rst, input logic pin);
    int   i, t, p;
    logic r;
    exp_new = 1'b0;
    if (rst) begin
      hist.delete();
      mode        = 0;
      last_t      = 0;
      exp_period  = 8'd0;
      exp_valid   = 1'b0;
      exp_timeout = 1'b0;
    end else begin
      hist.push_back(pin);
      t = hist.size() - 1;
      i = t - LAT;
      r = 1'b0;
      if (i >= 1) r = hist[i] && !hist[i-1];
      if (mode == 1 && !r && (t - last_t) == TO_CYC) begin
        mode        = 2;
        exp_timeout = 1'b1;
        exp_valid   = 1'b0;
        exp_period  = 8'd0;
      end
      if (r) begin
        if (mode == 1) begin
          p          = (t - last_t) / MS;
          exp_period = (p > 255) ? 8'd255 : 8'(p);
          exp_valid  = 1'b1;
          exp_new    = 1'b1;
        end
        if (mode == 2) exp_timeout = 1'b0;
        mode   = 1;
        last_t = t;
      end
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cycle, got, want);
    end
  endtask

  // Inputs change on the falling edge; outputs are compared on the following falling edge.
  task automatic apply_stimulus(input logic rst, input logic pin);
    reset    = rst;
    pulse_in = pin;
    @(posedge clk);
    cycle++;
    model_step(rst, pin);
    @(negedge clk);
    strobes += int'(new_sample);
    check_output("outputs{period,valid,new_sample,timeout}",
                 {21'd0, period_ms, valid, new_sample, timeout},
                 {21'd0, exp_period, exp_valid, exp_new, exp_timeout});
  endtask

  task automatic pulse_train(input int gap, input int high, input int reps);
    for (int r = 0; r < reps; r++)
      for (int c = 0; c < gap; c++)
        apply_stimulus(1'b0, c < high);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k, gap, high;

    segs[0] = '{gap: 100, high: 1,  reps: 4, exp_samples: 3, exp_period: 8'd10};
    segs[1] = '{gap: 109, high: 1,  reps: 3, exp_samples: 3, exp_period: 8'd10};
    segs[2] = '{gap: 110, high: 1,  reps: 3, exp_samples: 3, exp_period: 8'd11};
    segs[3] = '{gap: 50,  high: 10, reps: 3, exp_samples: 3, exp_period: 8'd5};
    segs[4] = '{gap: 199, high: 1,  reps: 2, exp_samples: 2, exp_period: 8'd19};
    segs[5] = '{gap: 200, high: 1,  reps: 2, exp_samples: 2, exp_period: 8'd20};
    segs[6] = '{gap: 15,  high: 1,  reps: 3, exp_samples: 3, exp_period: 8'd1};
    segs[7] = '{gap: 9,   high: 1,  reps: 3, exp_samples: 3, exp_period: 8'd0};
    segs[8] = '{gap: 3,   high: 1,  reps: 4, exp_samples: 4, exp_period: 8'd0};

    reset    = 1'b1;
    pulse_in = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0);
    check_output("reset_state", {21'd0, period_ms, valid, new_sample, timeout}, 32'd0);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0);

    // Table of pulse trains; each row's first pulse measures the previous row's gap.
    for (int s = 0; s < 9; s++) begin
      strobes = 0;
      pulse_train(segs[s].gap, segs[s].high, segs[s].reps);
      check_output($sformatf("seg%0d_samples", s), strobes, segs[s].exp_samples);
      check_output($sformatf("seg%0d_period", s), {24'd0, period_ms}, {24'd0, segs[s].exp_period});
      check_output($sformatf("seg%0d_valid", s), {31'd0, valid}, 32'd1);
    end

    // Stream stops: timeout must appear TO_CYC clk after the last visible edge.
    k = 0;
    for (int i = 1; i <= 400; i++) begin
      apply_stimulus(1'b0, 1'b0);
      k = i;
      if (timeout) break;
    end
    check_output("timeout_latency", k, 198 + LAT);
    check_output("timeout_valid", {31'd0, valid}, 32'd0);
    check_output("timeout_period", {24'd0, period_ms}, 32'd0);
    strobes = 0;
    pulse_train(100, 1, 1);
    check_output("recovery_no_strobe", strobes, 0);
    check_output("recovery_timeout_clear", {31'd0, timeout}, 32'd0);
    strobes = 0;
    pulse_train(100, 1, 2);
    check_output("after_recovery_samples", strobes, 2);
    check_output("after_recovery_period", {24'd0, period_ms}, 32'd10);

    // One-cycle reset in the middle of a measurement.
    for (int i = 0; i < 50; i++) apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0);
    check_output("reset_midstream", {21'd0, period_ms, valid, new_sample, timeout}, 32'd0);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0);
    strobes = 0;
    pulse_train(100, 1, 1);
    check_output("post_reset_first_no_strobe", strobes, 0);
    strobes = 0;
    pulse_train(70, 1, 2);
    check_output("post_reset_samples", strobes, 2);
    check_output("post_reset_period", {24'd0, period_ms}, 32'd7);

    // Pulse rising during reset and held high across release is not an edge.
    strobes = 0;
    apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 1'b1);
    for (int i = 0; i < 40; i++) apply_stimulus(1'b0, 1'b0);
    pulse_train(100, 1, 2);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0);
    check_output("held_high_reset_samples", strobes, 1);
    check_output("held_high_reset_period", {24'd0, period_ms}, 32'd10);

    // Random pulse trains, some long enough to time out.
    for (int n = 0; n < 25; n++) begin
      gap  = $urandom_range(260, 2);
      high = $urandom_range(gap - 1, 1);
      pulse_train(gap, high, 1);
    end
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
